// File: rtl/mssd_pkg.sv
// Shared types and helpers for the multiport serial demultiplexer.
package mssd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        CNT  = 3'd2,
        PAR  = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Standard hex glyphs for a single seven-segment digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mssd_multi_if.sv
// Button/switch inputs and LED/segment outputs of the demultiplexer.
interface mssd_multi_if #(
    parameter int unsigned NPORT = 4
);
    logic             clkpb;
    logic             serin;
    logic [NPORT-1:0] p;
    logic             valid;
    logic             done;
    logic             err;
    logic [6:0]       sevseg;

    modport master (
        output clkpb, serin,
        input  p, valid, done, err, sevseg
    );

    modport slave (
        input  clkpb, serin,
        output p, valid, done, err, sevseg
    );
endinterface

// File: rtl/mssd_sync_edge.sv
// Synchronises the button clock and serial data, and turns each
// button rise into a single-cycle strobe with its sampled data bit.
module mssd_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clkpb,
    input  logic serin,
    output logic bit_stb,
    output logic ser_bit
);

    logic [SYNC_STAGES-1:0] pb_sync;
    logic [SYNC_STAGES-1:0] ser_sync;
    logic                   pb_prev;

    // Synchroniser chains plus registered rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_sync  <= '0;
            ser_sync <= '0;
            pb_prev  <= 1'b0;
            bit_stb  <= 1'b0;
            ser_bit  <= 1'b0;
        end else begin
            pb_sync  <= {pb_sync[SYNC_STAGES-2:0], clkpb};
            ser_sync <= {ser_sync[SYNC_STAGES-2:0], serin};
            pb_prev  <= pb_sync[SYNC_STAGES-1];
            bit_stb  <= pb_sync[SYNC_STAGES-1] & ~pb_prev;
            ser_bit  <= ser_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/mssd_multi.sv
// Serial-to-multiport demultiplexer: start bit, address, count,
// optional parity bit, then payload bits routed to one output port.
// Optional feature: MSSD_PARITY_EN adds an even-parity bit after the
// count field covering the address and count bits.
module mssd_multi
    import mssd_pkg::*;
#(
    parameter int unsigned NPORT       = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    mssd_multi_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(NPORT);
    localparam int unsigned BCNT_W = 3;
    localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_W - 1);
    localparam logic [BCNT_W-1:0] CNT_LAST  = BCNT_W'(CNT_W - 1);
    localparam logic [ADDR_W:0]   NPORT_LIM = (ADDR_W + 1)'(NPORT);

    logic              bit_stb;
    logic              ser_bit;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [NPORT-1:0]  p_q, p_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [6:0]        seg_q, seg_d;
    logic              addr_bad_c;

    mssd_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .clkpb  (bus.clkpb),
        .serin  (bus.serin),
        .bit_stb(bit_stb),
        .ser_bit(ser_bit)
    );

    assign addr_bad_c = ({1'b0, addr_q} >= NPORT_LIM);

    // State register, field registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= SEG_ZERO;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            p_q     <= p_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    // Frame decoder: advances one step per strobe, outputs follow next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        p_d     = p_q;
        err_d   = err_q;

        if (bit_stb) begin
            case (state_q)
                IDLE: begin
                    if (!ser_bit) begin
                        state_d = ADDR;
                        addr_d  = '0;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                    end
                end
                ADDR: begin
                    addr_d = ADDR_W'({addr_q, ser_bit});
                    if (bcnt_q == ADDR_LAST) begin
                        bcnt_d  = '0;
                        state_d = CNT;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
                CNT: begin
                    cnt_d = CNT_W'({cnt_q, ser_bit});
                    if (bcnt_q == CNT_LAST) begin
                        bcnt_d = '0;
`ifdef MSSD_PARITY_EN
                        state_d = PAR;
`else
                        if (cnt_d == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = DATA;
                            err_d   = addr_bad_c;
                        end
`endif
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
`ifdef MSSD_PARITY_EN
                PAR: begin
                    // Address, count and parity bit together must hold an even number of ones
                    if (^{addr_q, cnt_q, ser_bit}) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                        err_d   = addr_bad_c;
                    end
                end
`endif
                DATA: begin
                    p_d   = addr_bad_c ? '0 : (NPORT'(ser_bit) << addr_q);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Leaving DONE clears the frame; this strobe doubles as an IDLE bit
                    p_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    bcnt_d  = '0;
                    state_d = ser_bit ? IDLE : ADDR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        valid_d = (state_d == DATA);
        done_d  = (state_d == DONE);
        seg_d   = hex_to_seg(4'(cnt_d));
    end

    assign bus.p      = p_q;
    assign bus.valid  = valid_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.sevseg = seg_q;

endmodule
